// File: rtl/shiftreg_pkg.sv
// Shared constants for the shift register.
// Holds the default and minimum legal register width.
// Imported by the shift register top.
package shiftreg_pkg;

  // Default register width when no override is given.
  localparam int unsigned SHIFT_LEN_DEFAULT = 8;

  // Smallest width for which a shift {reg[N-2:0], sin} is meaningful.
  localparam int unsigned SHIFT_LEN_MIN = 2;

endpackage

// File: rtl/shiftreg.sv
// N-bit parallel-load, serial-in/serial-out left shift register.
// Latency: load/shift visible on data_out one clk edge after sampling; sout is the live MSB.
// Backpressure: none; the register shifts every cycle that is not a load.
module shiftreg
  import shiftreg_pkg::*;
#(
  parameter int N = SHIFT_LEN_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         sin,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out,
  output logic         sout
);

  // A width below two leaves no bits to carry across a shift.
  if (N < int'(SHIFT_LEN_MIN)) begin : g_bad_width
    $error("shiftreg: N must be at least 2");
  end

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;

  // Load has priority; otherwise shift left with sin entering at bit 0.
  assign data_d = load ? data_in : {data_q[N-2:0], sin};

  // Register with asynchronous clear; every bit is reset so nothing starts as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;
  // The MSB is the bit the next shift discards.
  assign sout     = data_q[N-1];

endmodule

// File: tb/tb_shiftreg.sv
// Self-checking bench for shiftreg.
// Table-driven load/shift vectors plus hand sequences for reset corners.
// Expected values are hand-computed for an 8-bit register.
`ifndef SHIFT_LEN
`define SHIFT_LEN 8
`endif

module tb_shiftreg;

  localparam int N = `SHIFT_LEN;

  logic         clk;
  logic         reset;
  logic         load;
  logic         sin;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         sout;

  int checks;
  int failures;

  shiftreg #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .sin      (sin),
    .data_in  (data_in),
    .data_out (data_out),
    .sout     (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic         sin;
    logic [N-1:0] din;
    logic [N-1:0] exp_out;
    logic         exp_sout;
  } vec_t;

  vec_t vecs[$];

  task automatic check_out(input string name, input logic [N-1:0] exp_out, input logic exp_sout);
    checks = checks + 1;
    if (data_out !== exp_out) begin
      failures = failures + 1;
      $display("FAIL %s data_out: got %h expected %h", name, data_out, exp_out);
    end
    checks = checks + 1;
    if (sout !== exp_sout) begin
      failures = failures + 1;
      $display("FAIL %s sout: got %b expected %b", name, sout, exp_sout);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic s, input logic [7:0] d,
                              input logic [7:0] e, input logic so);
    vec_t v;
    v.load     = l;
    v.sin      = s;
    v.din      = N'(d);
    v.exp_out  = N'(e);
    v.exp_sout = so;
    return v;
  endfunction

  // Drive between edges, then sample just after the next rising edge.
  task automatic step(input logic l, input logic s, input logic [N-1:0] d);
    @(negedge clk);
    load    = l;
    sin     = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // load, sin, data_in, expected data_out, expected sout
    vecs.push_back(mk(1'b1, 1'b0, 8'hAA, 8'hAA, 1'b1)); // parallel load
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h54, 1'b0)); // shift zero
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'hA8, 1'b1)); // shift zero
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h51, 1'b0)); // shift one
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'hA2, 1'b1)); // shift zero
    vecs.push_back(mk(1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0)); // load beats shift
    vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1)); // load all ones
    // Eight shifts of 1,0,1,1,0,0,1,0: register ends holding exactly those bits
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'hFD, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'hFB, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'hF6, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'hEC, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'hD9, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'hB2, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1)); // reload before reset test

    // Reset asserted at time zero clears without any clock edge.
    reset   = 1'b1;
    load    = 1'b1;
    sin     = 1'b1;
    data_in = N'(8'h5A);
    #1;
    check_out("reset_async_start", '0, 1'b0);
    // Held in reset across two edges with load and sin active.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_held", '0, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].load, vecs[i].sin, vecs[i].din);
      check_out($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_sout);
    end

    // Mid-cycle reset: contents vanish at once, no edge needed.
    @(negedge clk);
    load    = 1'b0;
    sin     = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_out("reset_mid_cycle", '0, 1'b0);

    // Load ignored while reset stays high.
    load    = 1'b1;
    data_in = N'(8'hC3);
    @(posedge clk);
    #1;
    check_out("reset_ignores_load", '0, 1'b0);

    // First edge after release acts normally: shift in a one.
    @(negedge clk);
    reset   = 1'b0;
    load    = 1'b0;
    sin     = 1'b1;
    @(posedge clk);
    #1;
    check_out("after_release", N'(8'h01), 1'b0);

    step(1'b0, 1'b1, '0);
    check_out("after_release_2", N'(8'h03), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
